branch_resolution_unit: RTL and testbench

Commit-side counterpart of the N-bit branch predictor in the SSOOO core. Records each prediction made at decode (direction plus fall-through PC) in an in-order FIFO. At commit it compares the recorded prediction with the resolved outcome and drives the predictor's training inputs (`Wrong_prediction`, `Commit_opcode`). On a misprediction it also issues the front-end redirect/flush and maintains branch and misprediction statistics.

---
 rtl/branch_resolution_unit.sv | 148 ++++++++++++++
 tb/tb_branch_resolution_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
//
// Commit-side partner of the N-bit branch predictor. Every branch predicted
// at decode is recorded in an in-order FIFO as {predicted direction,
// fall-through PC}. When the branch commits, the recorded direction is
// compared with the resolved one. The unit then drives the predictor's
// training outputs. On a misprediction it also issues the front-end redirect
// and flushes every younger entry.
//
// Parameters
//   DEPTH  maximum in-flight predicted branches (power of two, 2..64)
//   CNT_W  width of the saturating statistics counters
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   dec_valid         decoded instruction present
//   Decoded_opcode    its opcode
//   dec_pc            its PC (word addressed)
//   predicted         predictor direction for it (1 = taken)
//   cmt_valid         instruction committing
//   cmt_opcode        committing opcode
//   cmt_taken         resolved direction
//   cmt_target        resolved taken target
//   Commit_opcode     registered committed-branch opcode, 0 otherwise
//   Wrong_prediction  registered one-cycle misprediction flag
//   redirect_valid    one-cycle flush/redirect strobe
//   redirect_pc       correct fetch PC, held between redirects
//   full, empty       FIFO occupancy status (from registered count)
//   protocol_err      sticky error: overflow push or commit while empty
//   branch_cnt        committed branches, saturating
//   mispredict_cnt    mispredicted branches, saturating
module branch_resolution_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [11:0]      Decoded_opcode,
    input  logic [31:0]      dec_pc,
    input  logic             predicted,
    input  logic             cmt_valid,
    input  logic [11:0]      cmt_opcode,
    input  logic             cmt_taken,
    input  logic [31:0]      cmt_target,
    output logic [11:0]      Commit_opcode,
    output logic             Wrong_prediction,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             full,
    output logic             empty,
    output logic             protocol_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    // Shared opcode definitions: major opcode in bits [11:6], 4 = beq, 5 = bne.
    localparam logic [11:0] OPC_BEQ = 12'h100;
    localparam logic [11:0] OPC_BNE = 12'h140;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

    function automatic logic is_branch(input logic [11:0] op);
        return (op == OPC_BEQ) || (op == OPC_BNE);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             pred_mem [DEPTH];
    logic [31:0]      ft_mem   [DEPTH];
    logic [PTR_W-1:0] head_p0;
    logic [PTR_W-1:0] tail_p0;
    logic [PTR_W:0]   count_p0;

    logic        dec_br;
    logic        cmt_br;
    logic        pop;
    logic        mismatch;
    logic        push;
    logic        err_now;
    logic [31:0] correct_pc;

    assign full  = (count_p0 == DEPTH_C);
    assign empty = (count_p0 == '0);

    // ---- decode / commit evaluation (against registered FIFO state) ----
    always_comb begin
        dec_br     = dec_valid && is_branch(Decoded_opcode);
        cmt_br     = cmt_valid && is_branch(cmt_opcode);
        pop        = cmt_br && !empty;
        mismatch   = pop && (pred_mem[head_p0] ^ cmt_taken);
        // A pop frees a slot even when full; a flush squashes the younger push.
        push       = dec_br && (!full || pop) && !mismatch;
        err_now    = (dec_br && full && !pop) || (cmt_br && empty);
        correct_pc = cmt_taken ? cmt_target : ft_mem[head_p0];
    end

    // FIFO storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pred_mem[tail_p0] <= predicted;
            ft_mem[tail_p0]   <= dec_pc + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= '0;
        end else if (mismatch) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= '0;
        end else begin
            if (push) tail_p0 <= tail_p0 + 1'b1;
            if (pop)  head_p0 <= head_p0 + 1'b1;
            if (push && !pop)      count_p0 <= count_p0 + ONE_C;
            else if (pop && !push) count_p0 <= count_p0 - ONE_C;
        end
    end

    // ---- resolution register: training, redirect and statistics ----
    always_ff @(posedge clk) begin
        if (rst) begin
            Commit_opcode    <= '0;
            Wrong_prediction <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            protocol_err     <= 1'b0;
            branch_cnt       <= '0;
            mispredict_cnt   <= '0;
        end else begin
            Commit_opcode    <= pop ? cmt_opcode : 12'd0;
            Wrong_prediction <= mismatch;
            redirect_valid   <= mismatch;
            if (mismatch) redirect_pc <= correct_pc;
            if (err_now) protocol_err <= 1'b1;
            if (pop) branch_cnt <= sat_inc(branch_cnt);
            if (mismatch) mispredict_cnt <= sat_inc(mispredict_cnt);
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Testbench for branch_resolution_unit. Two instances share the stimulus:
// one with default parameters and one with CNT_W = 4 for counter saturation.
// Expected behaviour comes from a queue-based model of the prediction FIFO.
module tb_branch_resolution_unit;

    localparam int DEPTH = 8;
    localparam logic [11:0] BEQ = 12'h100;
    localparam logic [11:0] BNE = 12'h140;
    localparam logic [11:0] ADD = 12'h020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid = 1'b0;
    logic [11:0] Decoded_opcode = '0;
    logic [31:0] dec_pc = '0;
    logic        predicted = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [11:0] cmt_opcode = '0;
    logic        cmt_taken = 1'b0;
    logic [31:0] cmt_target = '0;

    logic [11:0] Commit_opcode, Commit_opcode4;
    logic        Wrong_prediction, Wrong_prediction4;
    logic        redirect_valid, redirect_valid4;
    logic [31:0] redirect_pc, redirect_pc4;
    logic        full, full4, empty, empty4, protocol_err, protocol_err4;
    logic [31:0] branch_cnt, mispredict_cnt;
    logic [3:0]  branch_cnt4, mispredict_cnt4;

    int tests_run = 0;
    int tests_failed = 0;

    branch_resolution_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .Decoded_opcode(Decoded_opcode),
        .dec_pc(dec_pc), .predicted(predicted), .cmt_valid(cmt_valid),
        .cmt_opcode(cmt_opcode), .cmt_taken(cmt_taken), .cmt_target(cmt_target),
        .Commit_opcode(Commit_opcode), .Wrong_prediction(Wrong_prediction),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .full(full),
        .empty(empty), .protocol_err(protocol_err), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt));

    branch_resolution_unit #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .Decoded_opcode(Decoded_opcode),
        .dec_pc(dec_pc), .predicted(predicted), .cmt_valid(cmt_valid),
        .cmt_opcode(cmt_opcode), .cmt_taken(cmt_taken), .cmt_target(cmt_target),
        .Commit_opcode(Commit_opcode4), .Wrong_prediction(Wrong_prediction4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4), .full(full4),
        .empty(empty4), .protocol_err(protocol_err4), .branch_cnt(branch_cnt4),
        .mispredict_cnt(mispredict_cnt4));

    always #5 clk = ~clk;

    // Behavioural model: queue of outstanding predictions plus expected outputs.
    typedef struct { logic pred; logic [31:0] ft; } entry_t;
    entry_t      q[$];
    logic [11:0] m_opc;
    logic        m_wp;
    logic [31:0] m_rpc;
    logic        m_err;
    longint      m_br;
    longint      m_mis;

    function automatic logic is_br(input logic [11:0] op);
        return op == BEQ || op == BNE;
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step();
        logic   dbr, cbr, pop, mis;
        int     n;
        entry_t e;
        if (rst) begin
            q.delete();
            m_opc = 0; m_wp = 0; m_rpc = 0; m_err = 0; m_br = 0; m_mis = 0;
            return;
        end
        n   = q.size();
        dbr = dec_valid && is_br(Decoded_opcode);
        cbr = cmt_valid && is_br(cmt_opcode);
        pop = cbr && n > 0;
        mis = pop && (q[0].pred != cmt_taken);
        if ((dbr && n == DEPTH && !pop) || (cbr && n == 0)) m_err = 1;
        m_opc = pop ? cmt_opcode : 12'd0;
        m_wp  = mis;
        if (pop) m_br++;
        if (mis) begin
            m_mis++;
            m_rpc = cmt_taken ? cmt_target : q[0].ft;
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (dbr && (n < DEPTH || pop)) begin
                e.pred = predicted;
                e.ft   = dec_pc + 32'd1;
                q.push_back(e);
            end
        end
    endtask

    // Advance one clock: update the model from the driven inputs, then leave
    // time #1 after the edge so outputs can be sampled and inputs changed.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; Decoded_opcode = '0; dec_pc = '0; predicted = 0;
        cmt_valid = 0; cmt_opcode = '0; cmt_taken = 0; cmt_target = '0;
    endtask

    task automatic push_in(input logic [11:0] op, input logic [31:0] pc, input logic p);
        dec_valid = 1; Decoded_opcode = op; dec_pc = pc; predicted = p;
    endtask

    task automatic commit_in(input logic [11:0] op, input logic t, input logic [31:0] tgt);
        cmt_valid = 1; cmt_opcode = op; cmt_taken = t; cmt_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (Commit_opcode !== 12'd0) begin tests_failed++; $display("FAIL reset_opc got=%h exp=0", Commit_opcode); end
        tests_run++; if ({Wrong_prediction, redirect_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_wp_rv got=%b exp=00", {Wrong_prediction, redirect_valid}); end
        tests_run++; if (redirect_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
        tests_run++; if ({full, empty, protocol_err} !== 3'b010) begin tests_failed++; $display("FAIL reset_flags got=%b exp=010", {full, empty, protocol_err}); end
        tests_run++; if (branch_cnt !== 0 || mispredict_cnt !== 0) begin tests_failed++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); end
    endtask

    task automatic test_basic();
        push_in(BEQ, 32'h10, 1); cycle(); idle();
        tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL basic_push_empty got=%b exp=0", empty); end
        commit_in(BEQ, 1, 32'h40); cycle(); idle();
        tests_run++; if (Commit_opcode !== BEQ) begin tests_failed++; $display("FAIL basic_opc got=%h exp=%h", Commit_opcode, BEQ); end
        tests_run++; if (Wrong_prediction !== 1'b0) begin tests_failed++; $display("FAIL basic_wp got=%b exp=0", Wrong_prediction); end
        tests_run++; if (branch_cnt !== 32'd1) begin tests_failed++; $display("FAIL basic_bcnt got=%0d exp=1", branch_cnt); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_nt_mispredict();
        push_in(BNE, 32'h20, 1); cycle();
        push_in(BNE, 32'h24, 1); cycle();
        push_in(BNE, 32'h28, 1); cycle(); idle();
        commit_in(BNE, 0, 32'h999); cycle(); idle();
        tests_run++; if ({Wrong_prediction, redirect_valid} !== 2'b11) begin tests_failed++; $display("FAIL nt_wp_rv got=%b exp=11", {Wrong_prediction, redirect_valid}); end
        tests_run++; if (redirect_pc !== 32'h21) begin tests_failed++; $display("FAIL nt_rpc got=%h exp=21", redirect_pc); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL nt_flush_empty got=%b exp=1", empty); end
        tests_run++; if (mispredict_cnt !== 32'd1) begin tests_failed++; $display("FAIL nt_mcnt got=%0d exp=1", mispredict_cnt); end
        cycle();
        tests_run++; if (redirect_valid !== 1'b0) begin tests_failed++; $display("FAIL nt_pulse got=%b exp=0", redirect_valid); end
        tests_run++; if (redirect_pc !== 32'h21) begin tests_failed++; $display("FAIL nt_rpc_hold got=%h exp=21", redirect_pc); end
    endtask

    task automatic test_taken_mispredict();
        push_in(BEQ, 32'h100, 0); cycle(); idle();
        commit_in(BEQ, 1, 32'h200); cycle(); idle();
        tests_run++; if (redirect_pc !== 32'h200) begin tests_failed++; $display("FAIL tk_rpc got=%h exp=200", redirect_pc); end
        tests_run++; if (redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL tk_rv got=%b exp=1", redirect_valid); end
        cycle();
        tests_run++; if (redirect_valid !== 1'b0) begin tests_failed++; $display("FAIL tk_pulse got=%b exp=0", redirect_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_in(BEQ, 32'h300 + i, 1); cycle();
        end
        idle();
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL full_set got=%b exp=1", full); end
        push_in(BNE, 32'h400, 1); cycle(); idle();
        tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL full_overflow_err got=%b exp=1", protocol_err); end
        push_in(BNE, 32'h500, 0); commit_in(BEQ, 1, 32'h0); cycle(); idle();
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL full_pushpop got=%b exp=1", full); end
        tests_run++; if (Commit_opcode !== BEQ) begin tests_failed++; $display("FAIL full_pushpop_opc got=%h exp=%h", Commit_opcode, BEQ); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            commit_in(BEQ, 1, 32'h0); cycle();
        end
        // The last entry is the one pushed while full (predicted not-taken).
        commit_in(BNE, 0, 32'h0); cycle(); idle();
        tests_run++; if (Commit_opcode !== BNE || Wrong_prediction !== 1'b0) begin tests_failed++; $display("FAIL full_accepted got=%h/%b exp=%h/0", Commit_opcode, Wrong_prediction, BNE); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_mispredict_push();
        do_reset();
        push_in(BEQ, 32'h600, 1); cycle();
        push_in(BEQ, 32'h604, 1); cycle(); idle();
        push_in(BEQ, 32'h608, 1); commit_in(BEQ, 0, 32'h0); cycle(); idle();
        tests_run++; if (empty !== 1'b1 || Wrong_prediction !== 1'b1) begin tests_failed++; $display("FAIL mp_push_flush got=%b/%b exp=1/1", empty, Wrong_prediction); end
        tests_run++; if (redirect_pc !== 32'h601) begin tests_failed++; $display("FAIL mp_push_rpc got=%h exp=601", redirect_pc); end
        tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL mp_push_noerr got=%b exp=0", protocol_err); end
    endtask

    task automatic test_errors_wrap();
        do_reset();
        commit_in(BEQ, 1, 32'h0); cycle(); idle();
        tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL empty_commit_err got=%b exp=1", protocol_err); end
        tests_run++; if (Commit_opcode !== 12'd0 || branch_cnt !== 32'd0) begin tests_failed++; $display("FAIL empty_commit_opc got=%h/%0d exp=0/0", Commit_opcode, branch_cnt); end
        // Same-edge push into empty FIFO is accepted; the commit is the error.
        push_in(BNE, 32'h700, 1); commit_in(BNE, 1, 32'h0); cycle(); idle();
        tests_run++; if (empty !== 1'b0 || Commit_opcode !== 12'd0) begin tests_failed++; $display("FAIL same_edge got=%b/%h exp=0/0", empty, Commit_opcode); end
        do_reset();
        tests_run++; if (protocol_err !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL midreset got=%b/%b exp=0/1", protocol_err, empty); end
        push_in(BEQ, 32'hFFFF_FFFF, 1); cycle(); idle();
        commit_in(BEQ, 0, 32'h1234); cycle(); idle();
        tests_run++; if (redirect_pc !== 32'h0 || redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_rpc got=%h/%b exp=0/1", redirect_pc, redirect_valid); end
        // Non-branch opcodes are ignored on both paths.
        push_in(ADD, 32'h10, 1); commit_in(ADD, 1, 32'h0); cycle(); idle();
        tests_run++; if (empty !== 1'b1 || Commit_opcode !== 12'd0 || protocol_err !== 1'b0) begin tests_failed++; $display("FAIL nonbranch got=%b/%h/%b exp=1/0/0", empty, Commit_opcode, protocol_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        push_in(BEQ, 32'h800, 1); cycle();
        for (int i = 1; i <= 17; i++) begin
            push_in(BNE, 32'h800 + i, 1);
            commit_in(BEQ, 1, 32'h0);
            cycle();
        end
        idle();
        tests_run++; if (branch_cnt4 !== 4'hF) begin tests_failed++; $display("FAIL sat_bcnt4 got=%h exp=f", branch_cnt4); end
        tests_run++; if (branch_cnt !== 32'd17) begin tests_failed++; $display("FAIL sat_bcnt32 got=%0d exp=17", branch_cnt); end
    endtask

    task automatic test_random();
        logic [11:0] ops[3];
        ops[0] = BEQ; ops[1] = BNE; ops[2] = ADD;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                push_in(ops[$urandom_range(0, 2)], $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) < 45)
                commit_in(ops[$urandom_range(0, 2)], 1'($urandom_range(0, 3) != 0), $urandom);
            if (c == 200) rst = 1;
            cycle();
            rst = 0;
            tests_run++;
            if (Commit_opcode !== m_opc || Wrong_prediction !== m_wp || redirect_valid !== m_wp ||
                redirect_pc !== m_rpc || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
                protocol_err !== m_err || branch_cnt !== 32'(m_br) || mispredict_cnt !== 32'(m_mis) ||
                branch_cnt4 !== 4'(sat(m_br, 15)) || mispredict_cnt4 !== 4'(sat(m_mis, 15))) begin
                tests_failed++;
                $display("FAIL random c=%0d got opc=%h wp=%b rv=%b rpc=%h f=%b e=%b err=%b b=%0d m=%0d b4=%0d m4=%0d exp opc=%h wp=%b rpc=%h n=%0d err=%b b=%0d m=%0d",
                         c, Commit_opcode, Wrong_prediction, redirect_valid, redirect_pc, full, empty,
                         protocol_err, branch_cnt, mispredict_cnt, branch_cnt4, mispredict_cnt4,
                         m_opc, m_wp, m_rpc, q.size(), m_err, m_br, m_mis);
            end
        end
        idle();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_nt_mispredict();
        test_taken_mispredict();
        test_full();
        test_mispredict_push();
        test_errors_wrap();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
